// File: rtl/nf10_router_output_demux.sv
// Router output demux: 4-deep fallthrough input FIFO feeding per-port one-beat output registers,
// steered by the TUSER destination mask. Optional statistics: NF10_OUTPUT_DEMUX_STATS_EN.

module nf10_router_output_demux_port #(
  parameter int DW = 256,
  parameter int UW = 128
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] strb_i,
  input  logic [UW-1:0]   user_i,
  input  logic            last_i,
  input  logic            tready_i,
  output logic            free_o,
  output logic            tvalid_o,
  output logic [DW-1:0]   tdata_o,
  output logic [DW/8-1:0] tstrb_o,
  output logic [UW-1:0]   tuser_o,
  output logic            tlast_o
);
  logic            vld_q, last_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;
  logic [UW-1:0]   user_q;

  assign free_o   = ~vld_q | tready_i;
  assign tvalid_o = vld_q;
  assign tdata_o  = data_q;
  assign tstrb_o  = strb_q;
  assign tuser_o  = user_q;
  assign tlast_o  = last_q;

  // A load wins over a drain, so a beat consumed and replaced in one cycle keeps TVALID high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
      user_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      last_q <= last_i;
      data_q <= data_i;
      strb_q <= strb_i;
      user_q <= user_i;
    end else if (tready_i) begin
      vld_q  <= 1'b0;
    end
  end
endmodule

module nf10_router_output_demux #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 8,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                                      AXI_ACLK,
  input  logic                                      AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]            S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]          S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]           S_AXIS_TUSER,
  input  logic                                      S_AXIS_TVALID,
  input  logic                                      S_AXIS_TLAST,
  output logic                                      S_AXIS_TREADY,
  output logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]  M_AXIS_TDATA,
  output logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] M_AXIS_TUSER,
  output logic [NUM_PORTS-1:0]                      M_AXIS_TVALID,
  output logic [NUM_PORTS-1:0]                      M_AXIS_TLAST,
  input  logic [NUM_PORTS-1:0]                      M_AXIS_TREADY
`ifdef NF10_OUTPUT_DEMUX_STATS_EN
  ,
  output logic [31:0]                               PKT_CNT,
  output logic [31:0]                               DROP_CNT
`endif
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef enum logic {HEADER, IN_PACKET} state_t;

  beat_t       mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  cnt_q;
  logic        fifo_full, fifo_empty, wr_en, pop;
  beat_t       head, in_beat;

  state_t                state_q;
  logic                  drop_q;
  logic [NUM_PORTS-1:0]  dst_mask_q, cur_mask, free, load;
  logic                  drop, all_free;

  assign in_beat       = '{data: S_AXIS_TDATA, strb: S_AXIS_TSTRB, user: S_AXIS_TUSER, last: S_AXIS_TLAST};
  assign fifo_full     = (cnt_q == 3'd4);
  assign fifo_empty    = (cnt_q == 3'd0);
  assign S_AXIS_TREADY = ~fifo_full & ~AXI_RESET;
  assign wr_en         = S_AXIS_TVALID & S_AXIS_TREADY;
  assign head          = mem_q[rd_ptr_q];

  always_ff @(posedge AXI_ACLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_beat;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 2'd1;
      cnt_q <= cnt_q + 3'(wr_en) - 3'(pop);
    end
  end

  // Header beats steer by their own TUSER; later beats of the packet follow the latched mask.
  always_comb begin
    cur_mask = dst_mask_q;
    drop     = drop_q;
    if (state_q == HEADER) begin
      cur_mask = head.user[DST_PORT_POS +: NUM_PORTS];
      drop     = ~|cur_mask;
    end
  end

  assign all_free = &(free | ~cur_mask);
  assign pop      = ~fifo_empty & (drop | all_free);
  assign load     = {NUM_PORTS{pop & ~drop}} & cur_mask;

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_q    <= HEADER;
      drop_q     <= 1'b0;
      dst_mask_q <= '0;
    end else if (pop) begin
      if (state_q == HEADER) dst_mask_q <= cur_mask;
      if (head.last) begin
        state_q <= HEADER;
        drop_q  <= 1'b0;
      end else begin
        state_q <= IN_PACKET;
        drop_q  <= drop;
      end
    end
  end

`ifdef NF10_OUTPUT_DEMUX_STATS_EN
  logic [31:0] pkt_cnt_q, drop_cnt_q;
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (pop & head.last) begin
      if (drop) drop_cnt_q <= drop_cnt_q + 32'd1;
      else      pkt_cnt_q  <= pkt_cnt_q + 32'd1;
    end
  end
  assign PKT_CNT  = pkt_cnt_q;
  assign DROP_CNT = drop_cnt_q;
`endif

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    nf10_router_output_demux_port #(.DW(DW), .UW(UW)) u_port (
      .clk_i    (AXI_ACLK),
      .rst_i    (AXI_RESET),
      .load_i   (load[g]),
      .data_i   (head.data),
      .strb_i   (head.strb),
      .user_i   (head.user),
      .last_i   (head.last),
      .tready_i (M_AXIS_TREADY[g]),
      .free_o   (free[g]),
      .tvalid_o (M_AXIS_TVALID[g]),
      .tdata_o  (M_AXIS_TDATA[g*DW +: DW]),
      .tstrb_o  (M_AXIS_TSTRB[g*SW +: SW]),
      .tuser_o  (M_AXIS_TUSER[g*UW +: UW]),
      .tlast_o  (M_AXIS_TLAST[g])
    );
  end
endmodule

// File: tb/tb_nf10_router_output_demux.sv
// Bench for nf10_router_output_demux: queue-based model checked every cycle plus directed literal checks.
module tb_nf10_router_output_demux;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [255:0]  s_tdata = '0;
  logic [31:0]   s_tstrb = '0;
  logic [127:0]  s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          S_AXIS_TREADY;
  logic [2047:0] M_AXIS_TDATA;
  logic [255:0]  M_AXIS_TSTRB;
  logic [1023:0] M_AXIS_TUSER;
  logic [7:0]    M_AXIS_TVALID, M_AXIS_TLAST;
  logic [7:0]    m_tready = 8'hFF;
`ifdef NF10_OUTPUT_DEMUX_STATS_EN
  logic [31:0]   PKT_CNT, DROP_CNT;
`endif

  nf10_router_output_demux dut (
    .AXI_ACLK(clk), .AXI_RESET(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(m_tready)
`ifdef NF10_OUTPUT_DEMUX_STATS_EN
    , .PKT_CNT(PKT_CNT), .DROP_CNT(DROP_CNT)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  int tests = 0, fails = 0;
  int cyc = 0;
  bit started = 0;

  // behavioural model: input queue, per-port held beat, current packet routing
  beat_t       mq[$];
  beat_t       mreg [8];
  bit          mv [8];
  bit          m_inpkt, m_drop;
  logic [7:0]  m_mask;
  int unsigned m_pkt, m_dropc;

  // delivery log: {port, last, tag}
  int dlog[$];
  int acc_cnt, first_acc;
  int first_tv [8];

  task automatic check(input string nm, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    bit acc, pop, drop, allf;
    logic [7:0] mask;
    beat_t h, inb;
    started = 1;
    cyc++;
    acc = s_tvalid && !rst && (mq.size() < 4);
    inb = '{d: s_tdata, s: s_tstrb, u: s_tuser, l: s_tlast};
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 8; i++) begin mv[i] = 0; mreg[i] = '0; end
      m_inpkt = 0; m_drop = 0; m_mask = '0; m_pkt = 0; m_dropc = 0;
    end else begin
      pop = 0; drop = 0; mask = '0; h = '0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (!m_inpkt) begin mask = h.u[31:24]; drop = (mask == 8'h00); end
        else begin mask = m_mask; drop = m_drop; end
        allf = 1;
        for (int i = 0; i < 8; i++) if (mask[i] && mv[i] && !m_tready[i]) allf = 0;
        pop = drop || allf;
      end
      for (int i = 0; i < 8; i++) begin
        if (pop && !drop && mask[i]) begin mreg[i] = h; mv[i] = 1; end
        else if (mv[i] && m_tready[i]) mv[i] = 0;
      end
      if (pop) begin
        mq.delete(0);
        if (h.l) begin
          m_inpkt = 0;
          if (drop) m_dropc++; else m_pkt++;
        end else begin
          m_inpkt = 1; m_mask = mask; m_drop = drop;
        end
      end
      if (acc) mq.push_back(inb);
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [7:0] ev;
    if (started) begin
      ev = '0;
      for (int i = 0; i < 8; i++) ev[i] = mv[i];
      check("tready", 512'(S_AXIS_TREADY), 512'(!rst && (mq.size() < 4)));
      check("tvalid", 512'(M_AXIS_TVALID), 512'(ev));
      for (int i = 0; i < 8; i++)
        if (mv[i])
          check("beat", 512'({M_AXIS_TDATA[i*256 +: 256], M_AXIS_TSTRB[i*32 +: 32],
                              M_AXIS_TUSER[i*128 +: 128], M_AXIS_TLAST[i]}), 512'(mreg[i]));
`ifdef NF10_OUTPUT_DEMUX_STATS_EN
      check("pkt_cnt", 512'(PKT_CNT), 512'(m_pkt));
      check("drop_cnt", 512'(DROP_CNT), 512'(m_dropc));
`endif
    end
  end

  always @(negedge clk) begin
    if (s_tvalid && S_AXIS_TREADY) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    for (int p = 0; p < 8; p++) begin
      if (M_AXIS_TVALID[p] && first_tv[p] < 0) first_tv[p] = cyc;
      if (M_AXIS_TVALID[p] && m_tready[p])
        dlog.push_back((p << 17) | (int'(M_AXIS_TLAST[p]) << 16) | int'(M_AXIS_TDATA[p*256 +: 16]));
    end
  end

  function automatic int port_cnt(input int p);
    int n = 0;
    foreach (dlog[k]) if ((dlog[k] >> 17) == p) n++;
    return n;
  endfunction

  function automatic int nth(input int p, input int idx);
    int n = 0;
    foreach (dlog[k]) if ((dlog[k] >> 17) == p) begin
      if (n == idx) return dlog[k] & 'h1FFFF;
      n++;
    end
    return -1;
  endfunction

  function automatic bit any_mv();
    for (int i = 0; i < 8; i++) if (mv[i]) return 1;
    return 0;
  endfunction

  task automatic clear_log();
    dlog.delete();
    acc_cnt = 0;
    first_acc = -1;
    for (int i = 0; i < 8; i++) first_tv[i] = -1;
  endtask

  task automatic send_beat(input logic [7:0] dst, input logic [15:0] tag, input bit last);
    int n = 0;
    bit rdy;
    s_tvalid = 1'b1;
    s_tdata  = {16{tag}};
    s_tstrb  = {2{tag}};
    s_tuser  = {64'h0, tag, 16'h0, dst, 24'h0};
    s_tlast  = last;
    do begin
      @(negedge clk); rdy = S_AXIS_TREADY;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 200);
    check("send_timeout", 512'(rdy), 512'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] dst0, input logic [7:0] dstn, input int nb, input logic [15:0] tag0);
    for (int b = 0; b < nb; b++)
      send_beat((b == 0) ? dst0 : dstn, tag0 + 16'(b), b == nb - 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((mq.size() != 0 || any_mv()) && n < 300) begin @(posedge clk); #1; n++; end
    check({nm, "_drain_timeout"}, 512'(n < 300), 512'(1));
    @(negedge clk);
    check({nm, "_idle"}, 512'(M_AXIS_TVALID), 512'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    clear_log();
    // reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_tvalid", 512'(M_AXIS_TVALID), 512'(0));
    check("rst_tlast", 512'(M_AXIS_TLAST), 512'(0));
    check("rst_tdata", 512'(M_AXIS_TDATA[511:0]), 512'(0));
    check("rst_tready", 512'(S_AXIS_TREADY), 512'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 512'(S_AXIS_TREADY), 512'(1));
    @(posedge clk); #1;

    // unicast to port 2
    clear_log();
    send_pkt(8'h04, 8'h04, 3, 16'h1100);
    drain("uni");
    check("uni_p2_cnt", 512'(port_cnt(2)), 512'(3));
    check("uni_total", 512'(dlog.size()), 512'(3));
    check("uni_b0", 512'(nth(2, 0)), 512'('h01100));
    check("uni_b1", 512'(nth(2, 1)), 512'('h01101));
    check("uni_b2_last", 512'(nth(2, 2)), 512'('h11102));
    check("uni_latency", 512'(first_tv[2] - first_acc), 512'(2));

    // multicast with port 2 backpressured
    clear_log();
    m_tready = 8'hFB;
    send_pkt(8'h05, 8'h05, 3, 16'h2200);
    repeat (5) begin @(posedge clk); #1; end
    check("mc_stall_p0", 512'(port_cnt(0)), 512'(1));
    check("mc_stall_p2", 512'(port_cnt(2)), 512'(0));
    m_tready = 8'hFF;
    drain("mc");
    check("mc_p0_cnt", 512'(port_cnt(0)), 512'(3));
    check("mc_p2_cnt", 512'(port_cnt(2)), 512'(3));
    for (int j = 0; j < 3; j++) begin
      check("mc_p0_seq", 512'(nth(0, j)), 512'(((j == 2) ? 'h10000 : 0) | ('h2200 + j)));
      check("mc_p2_seq", 512'(nth(2, j)), 512'(((j == 2) ? 'h10000 : 0) | ('h2200 + j)));
    end

    // drop then unicast to port 1
    do_reset();
    clear_log();
    send_pkt(8'h00, 8'h00, 4, 16'h3300);
    send_pkt(8'h02, 8'h02, 2, 16'h3400);
    drain("drop");
    check("drop_total", 512'(dlog.size()), 512'(2));
    check("drop_p1_b0", 512'(nth(1, 0)), 512'('h03400));
    check("drop_p1_b1", 512'(nth(1, 1)), 512'('h13401));
`ifdef NF10_OUTPUT_DEMUX_STATS_EN
    check("drop_cnt_lit", 512'(DROP_CNT), 512'(1));
    check("pkt_cnt_lit", 512'(PKT_CNT), 512'(1));
`endif

    // mask latched from header beat
    clear_log();
    send_pkt(8'h02, 8'h80, 2, 16'h4400);
    drain("latch");
    check("latch_p1", 512'(port_cnt(1)), 512'(2));
    check("latch_p7", 512'(port_cnt(7)), 512'(0));

    // FIFO full with all ports stalled
    clear_log();
    m_tready = 8'h00;
    fork
      send_pkt(8'h01, 8'h01, 10, 16'h5500);
      begin
        repeat (20) begin @(posedge clk); #1; end
        check("full_acc", 512'(acc_cnt), 512'(5));
        check("full_tready", 512'(S_AXIS_TREADY), 512'(0));
        m_tready = 8'hFF;
      end
    join
    drain("full");
    check("full_p0_cnt", 512'(port_cnt(0)), 512'(10));
    check("full_first", 512'(nth(0, 0)), 512'('h05500));
    check("full_last", 512'(nth(0, 9)), 512'('h15509));

    // reset in the middle of a packet
    clear_log();
    send_beat(8'h08, 16'h6600, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = {16{16'h6601}};
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", 512'(M_AXIS_TVALID), 512'(0));
    @(posedge clk); #1;
    send_pkt(8'h08, 8'h08, 2, 16'h6700);
    drain("midrst");
    check("midrst_p3_cnt", 512'(port_cnt(3)), 512'(2));
    check("midrst_first", 512'(nth(3, 0)), 512'('h06700));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
